// File: rtl/multi_voice_pwm_player_if.sv
// Command port for multi_voice_pwm_player.
//   cmd_valid       : command present (master -> slave)
//   cmd_ready       : slave can take a command (slave -> master)
//   cmd_voice       : target voice index
//   cmd_half_period : tone half-period in clock cycles, 0 = silent
//   cmd_volume      : voice amplitude
interface multi_voice_pwm_player_if #(
  parameter int VOICE_W = 2,
  parameter int DIV_W   = 20,
  parameter int VOL_W   = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [VOICE_W-1:0] cmd_voice;
  logic [DIV_W-1:0]   cmd_half_period;
  logic [VOL_W-1:0]   cmd_volume;

  modport master (output cmd_valid, cmd_voice, cmd_half_period, cmd_volume,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_voice, cmd_half_period, cmd_volume,
                  output cmd_ready);
endinterface

// File: rtl/multi_voice_pwm_player.sv
// Multi-voice square-wave tone player with a single PWM audio output.
// Each voice is a half-period counter toggling a phase bit; voices whose
// phase is high contribute their volume to a saturating sum that becomes the
// PWM duty for the next frame. Commands are staged in a one-entry shadow and
// applied to their voice only at a PWM frame boundary.
//   clk_100m     : system clock
//   rst          : synchronous reset, active high
//   enable       : audio output enable
//   cmd          : valid/ready command port (slave modport)
//   AUD_PWM      : PWM audio bit
//   AUD_SD       : amplifier shutdown-bar, follows enable one cycle late
//   frame_tick   : high on the last cycle of each PWM frame
//   voice_active : per-voice flag, half_period != 0 and volume != 0

// One tone voice: applied registers plus its counter/phase.
module multi_voice_pwm_voice #(
  parameter int DIV_W = 20,
  parameter int VOL_W = 4
) (
  input  logic             clk_100m,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] ld_half,
  input  logic [VOL_W-1:0] ld_vol,
  output logic             phase,
  output logic [VOL_W-1:0] vol,
  output logic             active
);
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      half  <= '0;
      vol   <= '0;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (load) begin
      // restart the tone from a known phase so the new pitch starts cleanly
      half  <= ld_half;
      vol   <= ld_vol;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (half == '0) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == half - 1'b1) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  assign active = (half != '0) && (vol != '0);
endmodule

module multi_voice_pwm_player #(
  parameter int NUM_VOICES = 4,
  parameter int DIV_W      = 20,
  parameter int VOL_W      = 4,
  parameter int PWM_W      = 8,
  parameter int VOICE_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  clk_100m,
  input  logic                  rst,
  input  logic                  enable,
  multi_voice_pwm_player_if.slave cmd,
  output logic                  AUD_PWM,
  output logic                  AUD_SD,
  output logic                  frame_tick,
  output logic [NUM_VOICES-1:0] voice_active
);
  localparam int SUM_W = VOL_W + $clog2(NUM_VOICES + 1);
  localparam int CMP_W = (SUM_W > PWM_W) ? SUM_W : PWM_W;
  localparam logic [PWM_W-1:0] PWM_MAX = '1;

  logic [PWM_W-1:0]   pwm_cnt;
  logic [PWM_W-1:0]   duty;
  logic               pending;
  logic [VOICE_W-1:0] sh_voice;
  logic [DIV_W-1:0]   sh_half;
  logic [VOL_W-1:0]   sh_vol;
  logic               boundary;

  logic [NUM_VOICES-1:0]            load;
  logic [NUM_VOICES-1:0]            phase;
  logic [NUM_VOICES-1:0][VOL_W-1:0] vol;

  logic [SUM_W-1:0] sum;
  logic [CMP_W-1:0] sum_ext;
  logic [PWM_W-1:0] sat;

  assign boundary      = (pwm_cnt == PWM_MAX);
  assign frame_tick    = boundary & ~rst;
  assign cmd.cmd_ready = ~pending;

  // Out-of-range voice indices match no bit, so such commands drain silently.
  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      load[i] = boundary & pending & (sh_voice == VOICE_W'(i));
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    multi_voice_pwm_voice #(.DIV_W(DIV_W), .VOL_W(VOL_W)) u_voice (
      .clk_100m (clk_100m),
      .rst      (rst),
      .load     (load[g]),
      .ld_half  (sh_half),
      .ld_vol   (sh_vol),
      .phase    (phase[g]),
      .vol      (vol[g]),
      .active   (voice_active[g])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (phase[i]) sum = sum + SUM_W'(vol[i]);
  end

  // Widen before comparing so saturation works whichever of SUM_W/PWM_W is larger.
  assign sum_ext = CMP_W'(sum);
  assign sat     = (sum_ext > CMP_W'(PWM_MAX)) ? PWM_MAX : sum_ext[PWM_W-1:0];

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      pwm_cnt  <= '0;
      duty     <= '0;
      pending  <= 1'b0;
      sh_voice <= '0;
      sh_half  <= '0;
      sh_vol   <= '0;
      AUD_PWM  <= 1'b0;
      AUD_SD   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      AUD_PWM <= (pwm_cnt < duty) & enable;
      AUD_SD  <= enable;
      if (boundary) duty <= sat;
      // apply and accept can never coincide: accept needs pending low
      if (boundary && pending) begin
        pending <= 1'b0;
      end else if (cmd.cmd_valid && !pending) begin
        pending  <= 1'b1;
        sh_voice <= cmd.cmd_voice;
        sh_half  <= cmd.cmd_half_period;
        sh_vol   <= cmd.cmd_volume;
      end
    end
  end
endmodule

// File: doc/multi_voice_pwm_player.md
Name: multi_voice_pwm_player

Overview:
Parametrised successor to the single-tune audio PWM player. It has N independent square-wave voices. Each voice has a programmable half-period and volume, written through a valid/ready command port. All voices are summed, saturated, and converted into a single PWM audio output. It sits beside the VGA display block under the demo top and drives AUD_PWM/AUD_SD directly, with register updates applied glitch-free at PWM frame boundaries.

Parameters:
NUM_VOICES, 4, number of tone voices (>=1)
DIV_W, 20, half-period counter width in clk_100m cycles
VOL_W, 4, per-voice volume width
PWM_W, 8, PWM frame resolution; frame length = 2^PWM_W cycles
VOICE_W, max(1,clog2(NUM_VOICES)), voice index width (derived)

Ports:
clk_100m  input  1  system clock, 100 MHz
rst  input  1  synchronous reset, active-high
enable  input  1  audio output enable
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_voice  input  VOICE_W  target voice index
cmd_half_period  input  DIV_W  tone half-period in cycles; 0 = silent
cmd_volume  input  VOL_W  voice amplitude
AUD_PWM  output  1  PWM audio bit
AUD_SD  output  1  amplifier shutdown-bar (1 = amp on)
frame_tick  output  1  one-cycle pulse on the last cycle of each PWM frame
voice_active  output  NUM_VOICES  per-voice flag: half_period!=0 and volume!=0

Behaviour:
- Reset (rst=1 at an edge) clears everything: all half_period, volume, tone counters and phases to 0; pwm_cnt=0; duty=0; pending=0; AUD_PWM=0; AUD_SD=0; frame_tick=0; voice_active=0.
- Reset mid-operation discards any staged command. cmd_valid is ignored while rst=1.
- Command handshake:
  - cmd_ready = ~pending, so it is 1 from the first cycle after reset.
  - Accept occurs on an edge where cmd_valid & cmd_ready. The fields are copied to the shadow register and pending is set.
  - At the next frame boundary edge (pwm_cnt == 2^PWM_W-1) with pending=1, the shadow is applied to the target voice: half_period and volume are loaded, and that voice's counter and phase are cleared to 0. Pending then clears.
  - A command accepted on a boundary edge is applied at the following boundary, 2^PWM_W cycles later.
  - If cmd_voice >= NUM_VOICES, the command is accepted and goes through the normal pending cycle, but it has no effect.
- Voice tone generation:
  - If half_period == 0, counter and phase are held at 0.
  - Otherwise the counter increments every cycle. When counter == half_period-1, the counter wraps to 0 and phase toggles.
  - Output period is 2*half_period cycles; half_period=1 toggles phase every cycle.
- Mixer:
  - sum = Σ (phase_i ? volume_i : 0), with width VOL_W+clog2(NUM_VOICES+1), evaluated combinationally from pre-edge state.
  - At each boundary edge: duty <= min(sum, 2^PWM_W-1), which saturates and never wraps.
  - The duty value is used for the whole next frame.
- PWM:
  - pwm_cnt free-runs 0..2^PWM_W-1 and wraps.
  - AUD_PWM is registered from (pwm_cnt < duty) & enable, so it lags pwm_cnt by 1 cycle.
  - duty=0 gives constant 0; duty=2^PWM_W-1 gives high for 2^PWM_W-1 of every 2^PWM_W cycles.
- frame_tick is combinational: (pwm_cnt == 2^PWM_W-1) & ~rst.
- AUD_SD is registered from enable, 1-cycle latency.
  - enable=0 forces AUD_PWM=0 on the next cycle.
  - Tone counters, pwm_cnt and command handling keep running regardless of enable.
- voice_active is combinational from the applied registers, not from the shadow.

Test Plan:
1. Reset: hold rst 3 cycles, then release → AUD_PWM=0, AUD_SD=0, voice_active=0, frame_tick first fires at cycle 255 after release, cmd_ready=1.
2. Single voice: enable=1; send voice0, half_period=512, volume=15 → cmd_ready=0 until the boundary edge, then voice_active=0001. Phase toggles every 2 frames. In frames latched with phase=1, AUD_PWM is high for exactly 15 of 256 cycles; otherwise it is 0.
3. Mixing/saturation with PWM_W=5: 4 voices, each half_period=1024 and volume=15, all applied → sum=60, duty saturates to 31, AUD_PWM high 31 of 32 cycles. With default PWM_W=8, duty=60.
4. Backpressure: issue two back-to-back commands (voice1, then voice2) → second is held with cmd_ready=0 until the first boundary. Voice1 is applied at boundary N and voice2 at boundary N+1; no command is lost.
5. Boundary cases:
   - NUM_VOICES=3, cmd_voice=3 → accepted, no register change.
   - half_period=0 on an active voice → voice_active bit clears and its contribution drops to 0 in the next frame's duty.
6. Enable/reset mid-run:
   - Drop enable → AUD_PWM=0 and AUD_SD=0 one cycle later.
   - Assert rst while pending=1 → the staged command is never applied and cmd_ready=1 after release.
